dot_product_stream: RTL and testbench

Parametrised streaming dot-product operator for a leaf page. It consumes paired elements from two ap_vld/ap_ack input streams, multiplies them, and accumulates VEC_LEN products per vector. It then emits the result and a status word on two ap_vld/ap_ack output streams. It replaces the fixed two-port dot-product operator and connects directly to leaf_interface user ports 1 and 2.

---
 rtl/dot_product_stream.sv | 224 ++++++++++++++++++++++
 tb/tb_dot_product_stream.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_product_stream.sv
// dot_product_stream: pairwise streaming dot product with result/status outputs.
// Build option DOT_SAT_EN: saturate Output_1 to the signed OUT_W range.
module dot_product_stream #(
    parameter int DATA_W  = 32,
    parameter int VEC_LEN = 16,
    parameter int OUT_W   = 32,
    parameter int ACC_W   = 2*DATA_W + $clog2(VEC_LEN) + 1
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              ap_start,
    output logic              ap_idle,
    output logic              ap_done,
    output logic              ap_ready,
    input  logic [DATA_W-1:0] Input_1_V_V,
    input  logic              Input_1_V_V_ap_vld,
    output logic              Input_1_V_V_ap_ack,
    input  logic [DATA_W-1:0] Input_2_V_V,
    input  logic              Input_2_V_V_ap_vld,
    output logic              Input_2_V_V_ap_ack,
    output logic [OUT_W-1:0]  Output_1_V_V,
    output logic              Output_1_V_V_ap_vld,
    input  logic              Output_1_V_V_ap_ack,
    output logic [OUT_W-1:0]  Output_2_V_V,
    output logic              Output_2_V_V_ap_vld,
    input  logic              Output_2_V_V_ap_ack
);

    localparam int PROD_W = 2*DATA_W;
    localparam int CNT_W  = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam int SEQ_W  = OUT_W - 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VEC_LEN - 1);

    typedef enum logic [1:0] {
        ACC   = 2'd0,
        DRAIN = 2'd1,
        EMIT  = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [CNT_W-1:0]         cnt_q;
    logic signed [PROD_W-1:0] prod_q;
    logic                     prod_v;
    logic                     first_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_d;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [PROD_W-1:0] a_ext;
    logic signed [PROD_W-1:0] b_ext;
    logic [OUT_W-1:0]         res_q;
    logic [OUT_W-1:0]         stat_q;
    logic [OUT_W-1:0]         res_d;
    logic                     res_v;
    logic                     stat_v;
    logic [SEQ_W-1:0]         seq_q;
    logic                     done_q;

    logic accept;
    logic last_pair;
    logic res_hs;
    logic stat_hs;
    logic res_left;
    logic stat_left;
    logic emit_fin;
    logic ovf;
    logic [ACC_W-OUT_W:0] acc_hi;

    assign last_pair = (cnt_q == CNT_LAST);
    assign res_hs    = res_v & Output_1_V_V_ap_ack;
    assign stat_hs   = stat_v & Output_2_V_V_ap_ack;
    assign res_left  = res_v & ~Output_1_V_V_ap_ack;
    assign stat_left = stat_v & ~Output_2_V_V_ap_ack;

    // State register
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= ACC;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, pairwise input acceptance and end-of-vector detection
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        emit_fin = 1'b0;
        unique case (state_q)
            ACC: begin
                accept = ap_rst_n & ap_start
                       & Input_1_V_V_ap_vld & Input_2_V_V_ap_vld;
                if (accept && last_pair) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = EMIT;
            end
            EMIT: begin
                emit_fin = ~res_left & ~stat_left;
                if (emit_fin) begin
                    state_d = ACC;
                end
            end
            default: begin
                state_d = ACC;
            end
        endcase
    end

    // Element counter, wraps on the last pair of a vector
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= last_pair ? '0 : cnt_q + CNT_W'(1);
        end
    end

    assign a_ext = {{DATA_W{Input_1_V_V[DATA_W-1]}}, Input_1_V_V};
    assign b_ext = {{DATA_W{Input_2_V_V[DATA_W-1]}}, Input_2_V_V};

    // Stage 1: register the signed product of each accepted pair
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            prod_q <= '0;
            prod_v <= 1'b0;
        end else begin
            prod_v <= accept;
            if (accept) begin
                prod_q <= a_ext * b_ext;
            end
        end
    end

    assign prod_ext = {{(ACC_W-PROD_W){prod_q[PROD_W-1]}}, prod_q};

    // Stage 2: first product loads, later products add
    always_comb begin
        acc_d = acc_q;
        if (prod_v) begin
            acc_d = first_q ? prod_ext : acc_q + prod_ext;
        end
    end

    // Accumulator and first-product marker
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            acc_q   <= '0;
            first_q <= 1'b1;
        end else begin
            acc_q <= acc_d;
            if (emit_fin) begin
                first_q <= 1'b1;
            end else if (prod_v) begin
                first_q <= 1'b0;
            end
        end
    end

    // Out of range when the bits above the OUT_W sign bit disagree
    assign acc_hi = acc_d[ACC_W-1:OUT_W-1];
    assign ovf    = ~((&acc_hi) | ~(|acc_hi));

    // Result word: saturated or wrapped low bits
    always_comb begin
        res_d = acc_d[OUT_W-1:0];
`ifdef DOT_SAT_EN
        if (ovf) begin
            res_d = acc_d[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                   : {1'b0, {(OUT_W-1){1'b1}}};
        end
`endif
    end

    // Output words load on DRAIN exit; each vld drops on its own handshake
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            res_q  <= '0;
            stat_q <= '0;
            res_v  <= 1'b0;
            stat_v <= 1'b0;
        end else if (state_q == DRAIN) begin
            res_q  <= res_d;
            stat_q <= {ovf, seq_q};
            res_v  <= 1'b1;
            stat_v <= 1'b1;
        end else begin
            if (res_hs) begin
                res_v <= 1'b0;
            end
            if (stat_hs) begin
                stat_v <= 1'b0;
            end
        end
    end

    // Sequence number and done pulse once both outputs are taken
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            seq_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= emit_fin;
            if (emit_fin) begin
                seq_q <= seq_q + SEQ_W'(1);
            end
        end
    end

    assign Input_1_V_V_ap_ack  = accept;
    assign Input_2_V_V_ap_ack  = accept;
    assign Output_1_V_V        = res_q;
    assign Output_1_V_V_ap_vld = res_v;
    assign Output_2_V_V        = stat_q;
    assign Output_2_V_V_ap_vld = stat_v;
    assign ap_done             = done_q;
    assign ap_ready            = done_q;
    assign ap_idle             = (state_q == ACC) && (cnt_q == '0)
                               && !res_v && !stat_v;

endmodule

// File: tb/tb_dot_product_stream.sv
// tb_dot_product_stream: directed and random streams against a sum-of-products model.
// Expected Output_1 follows the DOT_SAT_EN build option.
module tb_dot_product_stream;

    localparam int DW = 32;
    localparam int VL = 4;
    localparam int OW = 32;
    localparam logic signed [127:0] MAXV = (128'sd1 <<< (OW-1)) - 128'sd1;
    localparam logic signed [127:0] MINV = -(128'sd1 <<< (OW-1));

    logic ap_clk = 1'b0;
    logic ap_rst_n = 1'b0;
    logic ap_start = 1'b0;
    logic ap_idle, ap_done, ap_ready;
    logic [DW-1:0] in1 = '0, in2 = '0;
    logic in1_vld = 1'b0, in2_vld = 1'b0;
    logic in1_ack, in2_ack;
    logic [OW-1:0] out1, out2;
    logic out1_vld, out2_vld;
    logic out1_ack = 1'b1, out2_ack = 1'b1;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    dot_product_stream #(
        .DATA_W (DW),
        .VEC_LEN(VL),
        .OUT_W  (OW)
    ) dut (
        .ap_clk             (ap_clk),
        .ap_rst_n           (ap_rst_n),
        .ap_start           (ap_start),
        .ap_idle            (ap_idle),
        .ap_done            (ap_done),
        .ap_ready           (ap_ready),
        .Input_1_V_V        (in1),
        .Input_1_V_V_ap_vld (in1_vld),
        .Input_1_V_V_ap_ack (in1_ack),
        .Input_2_V_V        (in2),
        .Input_2_V_V_ap_vld (in2_vld),
        .Input_2_V_V_ap_ack (in2_ack),
        .Output_1_V_V       (out1),
        .Output_1_V_V_ap_vld(out1_vld),
        .Output_1_V_V_ap_ack(out1_ack),
        .Output_2_V_V       (out2),
        .Output_2_V_V_ap_vld(out2_vld),
        .Output_2_V_V_ap_ack(out2_ack)
    );

    always #5 ap_clk = ~ap_clk;

    always @(posedge ap_clk) cyc++;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: running sum of accepted products per vector
    logic signed [127:0] acc_m;
    logic signed [127:0] pa, pb;
    int n_m;
    logic [OW-2:0] seq_m;
    logic [OW-1:0] exp1_q[$];
    logic [OW-1:0] exp2_q[$];
    logic [OW-1:0] e1;
    logic ovf_m;
    int h1, h2, min_b, min_a;
    bit done_exp;
    int last_t;
    bit p1, p2;
    logic [OW-1:0] last_out1, last_out2;

    always @(negedge ap_clk) begin
        if (!ap_rst_n) begin
            acc_m = '0; n_m = 0; seq_m = '0;
            exp1_q.delete(); exp2_q.delete();
            h1 = 0; h2 = 0; done_exp = 0;
            last_t = -100; p1 = 0; p2 = 0;
        end else begin
            check("ack_gate", (in1_ack | in2_ack)
                  && !(in1_vld && in2_vld && ap_start), 0);
            check("ack_pair", in1_ack ^ in2_ack, 0);
            check("done", ap_done, done_exp);
            check("ready", ap_ready, done_exp);
            if (out1_vld && !p1) check("lat1", cyc - last_t, 2);
            if (out2_vld && !p2) check("lat2", cyc - last_t, 2);
            p1 = out1_vld;
            p2 = out2_vld;
            if (in1_vld && in1_ack) begin
                pa = $signed(in1);
                pb = $signed(in2);
                acc_m = acc_m + pa * pb;
                n_m++;
                if (n_m == VL) begin
                    ovf_m = (acc_m > MAXV) || (acc_m < MINV);
                    e1 = acc_m[OW-1:0];
`ifdef DOT_SAT_EN
                    if (ovf_m)
                        e1 = (acc_m < 0) ? {1'b1, {(OW-1){1'b0}}}
                                         : {1'b0, {(OW-1){1'b1}}};
`endif
                    exp1_q.push_back(e1);
                    exp2_q.push_back({ovf_m, seq_m});
                    seq_m = seq_m + 1'b1;
                    acc_m = '0;
                    n_m = 0;
                    last_t = cyc;
                end
            end
            min_b = (h1 < h2) ? h1 : h2;
            if (out1_vld && out1_ack) begin
                last_out1 = out1;
                if (exp1_q.size() == 0) check("out1_extra", 1, 0);
                else check("out1", out1, exp1_q.pop_front());
                h1++;
            end
            if (out2_vld && out2_ack) begin
                last_out2 = out2;
                if (exp2_q.size() == 0) check("out2_extra", 1, 0);
                else check("out2", out2, exp2_q.pop_front());
                h2++;
            end
            min_a = (h1 < h2) ? h1 : h2;
            done_exp = (min_a > min_b);
        end
    end

    task automatic send_pair(input logic [DW-1:0] a, input logic [DW-1:0] b);
        int w = 0;
        in1 = a; in2 = b; in1_vld = 1'b1; in2_vld = 1'b1;
        @(negedge ap_clk);
        while (!(in1_ack && in2_ack) && w < 100) begin
            w++;
            @(negedge ap_clk);
        end
        if (w >= 100) check("in_timeout", 1, 0);
        @(posedge ap_clk); #1;
        in1_vld = 1'b0; in2_vld = 1'b0;
    endtask

    task automatic send_vec(input logic [DW-1:0] a [VL],
                            input logic [DW-1:0] b [VL]);
        for (int i = 0; i < VL; i++) send_pair(a[i], b[i]);
    endtask

    task automatic wait_done();
        int w = 0;
        while (!ap_done && w < 60) begin
            @(negedge ap_clk);
            w++;
        end
        if (!ap_done) check("done_timeout", 1, 0);
        @(posedge ap_clk); #1;
    endtask

    function automatic logic [DW-1:0] rnd();
        int m = $urandom_range(0, 3);
        logic [DW-1:0] r;
        if (m == 0) r = $urandom;
        else if (m == 1) r = $urandom_range(0, 1) ? 32'h7FFFFFFF : 32'h80000000;
        else r = DW'($signed($urandom_range(0, 200)) - 100);
        return r;
    endfunction

    logic [DW-1:0] va [VL];
    logic [DW-1:0] vb [VL];

    initial begin
        int w;
        int sent;
        // Reset state with live inputs present
        in1_vld = 1'b1; in2_vld = 1'b1; ap_start = 1'b1;
        in1 = 32'd3; in2 = 32'd4;
        @(negedge ap_clk);
        check("rst_ack", in1_ack | in2_ack, 0);
        check("rst_idle", ap_idle, 1);
        check("rst_vld", {out1_vld, out2_vld}, 0);
        check("rst_done", {ap_done, ap_ready}, 0);
        @(posedge ap_clk); #1;
        in1_vld = 1'b0; in2_vld = 1'b0;
        ap_rst_n = 1'b1;

        // Basic vectors
        va = '{32'd1, 32'd2, 32'd3, 32'd4};
        vb = '{32'd5, 32'd6, 32'd7, 32'd8};
        send_vec(va, vb);
        wait_done();
        check("basic_out1", last_out1, 32'h46);
        check("basic_out2", last_out2, 32'h0);
        send_vec(va, vb);
        wait_done();
        check("basic2_out2", last_out2, 32'h1);

        // Signed vector
        va = '{-32'sd1, -32'sd2, -32'sd3, -32'sd4};
        vb = '{32'd1, 32'd1, 32'd1, 32'd1};
        send_vec(va, vb);
        wait_done();
        check("signed_out1", last_out1, 32'hFFFFFFF6);
        check("signed_ovf", last_out2[OW-1], 0);

        // Overflow vector
        va = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF};
        send_vec(va, va);
        wait_done();
        check("ovf_flag", last_out2[OW-1], 1);
`ifdef DOT_SAT_EN
        check("ovf_out1", last_out1, 32'h7FFFFFFF);
`else
        check("ovf_out1", last_out1, 32'h00000004);
`endif

        // Back-pressure on Output_1
        out1_ack = 1'b0;
        va = '{32'd1, 32'd2, 32'd3, 32'd4};
        send_vec(va, va);
        w = 0;
        while (!out1_vld && w < 20) begin
            @(negedge ap_clk);
            w++;
        end
        check("bp_vld_seen", out1_vld, 1);
        @(posedge ap_clk); #1;
        in1 = 32'd9; in2 = 32'd9; in1_vld = 1'b1; in2_vld = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge ap_clk);
            check("bp_vld", out1_vld, 1);
            check("bp_data", out1, 32'd30);
            check("bp_ack", in1_ack | in2_ack, 0);
        end
        @(posedge ap_clk); #1;
        in1_vld = 1'b0; in2_vld = 1'b0;
        out1_ack = 1'b1;
        wait_done();
        va = '{32'd1, 32'd2, 32'd3, 32'd4};
        vb = '{32'd5, 32'd6, 32'd7, 32'd8};
        send_vec(va, vb);
        wait_done();
        check("bp_next_out1", last_out1, 32'h46);

        // Skew: lone valid on Input_1
        in1 = 32'd7; in1_vld = 1'b1; in2_vld = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge ap_clk);
            check("skew_ack", in1_ack | in2_ack, 0);
            check("skew_idle", ap_idle, 1);
        end
        @(posedge ap_clk); #1;
        // Gating: both valid, start low
        ap_start = 1'b0; in2_vld = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge ap_clk);
            check("gate_ack", in1_ack | in2_ack, 0);
        end
        @(posedge ap_clk); #1;
        in1_vld = 1'b0; in2_vld = 1'b0; ap_start = 1'b1;

        // Reset mid-vector
        send_pair(32'd1, 32'd5);
        send_pair(32'd2, 32'd6);
        ap_rst_n = 1'b0;
        in1_vld = 1'b1; in2_vld = 1'b1;
        @(negedge ap_clk);
        check("mrst_ack", in1_ack | in2_ack, 0);
        check("mrst_idle", ap_idle, 1);
        @(posedge ap_clk); #1;
        in1_vld = 1'b0; in2_vld = 1'b0;
        ap_rst_n = 1'b1;
        send_vec(va, vb);
        wait_done();
        check("mrst_out1", last_out1, 32'h46);
        check("mrst_out2", last_out2, 32'h0);

        // Random traffic: valids, start and output acks all randomised
        sent = 0;
        w = 0;
        while (sent < 30 * VL && w < 5000) begin
            @(posedge ap_clk); #1;
            in1 = rnd(); in2 = rnd();
            in1_vld = ($urandom_range(0, 3) != 0);
            in2_vld = ($urandom_range(0, 3) != 0);
            ap_start = ($urandom_range(0, 7) != 0);
            out1_ack = $urandom_range(0, 1);
            out2_ack = $urandom_range(0, 1);
            @(negedge ap_clk);
            if (in1_vld && in1_ack) sent++;
            w++;
        end
        check("rand_sent", sent, 30 * VL);
        @(posedge ap_clk); #1;
        in1_vld = 1'b0; in2_vld = 1'b0; ap_start = 1'b1;
        out1_ack = 1'b1; out2_ack = 1'b1;
        w = 0;
        while ((exp1_q.size() != 0 || exp2_q.size() != 0) && w < 100) begin
            @(negedge ap_clk);
            w++;
        end
        repeat (3) @(negedge ap_clk);
        check("drain_q", exp1_q.size() + exp2_q.size(), 0);
        check("end_idle", ap_idle, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
